// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Receive-side handshake between the UART receiver FIFO and its consumer.
//   data_out       : head word, right-justified, upper bits zero
//   parity_err_out : parity error flag of the head word
//   frame_err_out  : stop-bit error flag of the head word
//   valid          : FIFO holds at least one word
//   ready          : consumer accepts the head word (pop on valid && ready)
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic [MAX_DATA_BITS-1:0] data_out;
    logic                     parity_err_out;
    logic                     frame_err_out;
    logic                     valid;
    logic                     ready;

    modport master (
        output data_out,
        output parity_err_out,
        output frame_err_out,
        output valid,
        input  ready
    );

    modport slave (
        input  data_out,
        input  parity_err_out,
        input  frame_err_out,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Oversampling UART receiver with 3-sample majority voting, false-start
// rejection, break detection, per-word parity/framing flags and a
// first-word-fall-through receive FIFO.
// Ports:
//   clk          : system clock
//   rst          : asynchronous reset, active-low
//   sample_en    : one-cycle strobe at OVERSAMPLE x baud
//   rx           : asynchronous serial input, idles high
//   parity_en    : frame carries a parity bit
//   parity_odd   : 0 = even parity, 1 = odd parity
//   stop_bits    : 0 = one stop bit, 1 = two stop bits
//   frame_length : data bits per frame (clamped to 5..MAX_DATA_BITS)
//   rx_if        : head word, flags, valid/ready handshake
//   break_det    : one-cycle pulse when a break is detected
//   overrun      : sticky, a word was dropped because the FIFO was full
//   fifo_level   : current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_en,
    input  logic                          rx,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop_bits,
    input  logic [3:0]                    frame_length,
    uart_rx_fifo_if.master                rx_if,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int SC_W   = $clog2(OVERSAMPLE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = MAX_DATA_BITS + 2;

    localparam logic [SC_W-1:0] SC_A    = SC_W'(OVERSAMPLE/2 - 1);
    localparam logic [SC_W-1:0] SC_B    = SC_W'(OVERSAMPLE/2);
    localparam logic [SC_W-1:0] SC_C    = SC_W'(OVERSAMPLE/2 + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT
    } state_t;

    // ---------------- synchroniser ----------------
    logic rx_meta_q, rxs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---------------- receiver FSM ----------------
    state_t                    state_q;
    logic [SC_W-1:0]           sc_q;
    logic [3:0]                bit_cnt_q;
    logic [3:0]                len_q;
    logic                      par_en_q, par_odd_q, stop2_q;
    logic [MAX_DATA_BITS-1:0]  data_q;
    logic                      s_a_q, s_b_q;
    logic                      perr_q, ferr_q;
    logic                      zero_q;          // every sampled bit so far was 0
    logic                      push_q;
    logic [WORD_W-1:0]         push_word_q;
    logic                      break_q;

    logic       maj, decide, sc_last;
    logic       stop_zero, ferr_now;
    logic [3:0] len_clamped;

    assign maj       = (s_a_q & s_b_q) | (s_a_q & rxs_q) | (s_b_q & rxs_q);
    assign decide    = (sc_q == SC_C);
    assign sc_last   = (sc_q == SC_LAST);
    // Break is only declared when the final stop bit is also low.
    assign stop_zero = zero_q & ~maj;
    assign ferr_now  = ferr_q | ~maj;

    always_comb begin
        len_clamped = frame_length;
        if (frame_length < 4'd5)
            len_clamped = 4'd5;
        else if (frame_length > 4'(MAX_DATA_BITS))
            len_clamped = 4'(MAX_DATA_BITS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sc_q        <= '0;
            bit_cnt_q   <= '0;
            len_q       <= 4'd5;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            data_q      <= '0;
            s_a_q       <= 1'b1;
            s_b_q       <= 1'b1;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            zero_q      <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            break_q     <= 1'b0;
        end else begin
            push_q  <= 1'b0;
            break_q <= 1'b0;
            if (sample_en) begin
                if (state_q != IDLE && state_q != BREAK_WAIT) begin
                    sc_q <= sc_last ? '0 : sc_q + 1'b1;
                    if (sc_q == SC_A) s_a_q <= rxs_q;
                    if (sc_q == SC_B) s_b_q <= rxs_q;
                end
                case (state_q)
                    IDLE: begin
                        if (!rxs_q) begin
                            len_q     <= len_clamped;
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                            stop2_q   <= stop_bits;
                            sc_q      <= '0;
                            bit_cnt_q <= '0;
                            data_q    <= '0;
                            perr_q    <= 1'b0;
                            ferr_q    <= 1'b0;
                            zero_q    <= 1'b1;
                            state_q   <= START;
                        end
                    end
                    START: begin
                        if (decide && maj)
                            state_q <= IDLE;        // false start
                        else if (sc_last)
                            state_q <= DATA;
                    end
                    DATA: begin
                        if (decide) begin
                            for (int i = 0; i < MAX_DATA_BITS; i++)
                                if (bit_cnt_q == 4'(i)) data_q[i] <= maj;
                            zero_q <= zero_q & ~maj;
                        end
                        if (sc_last) begin
                            if (bit_cnt_q == len_q - 4'd1)
                                state_q <= par_en_q ? PARITY : STOP1;
                            else
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    PARITY: begin
                        if (decide) begin
                            perr_q <= (^data_q) ^ maj ^ par_odd_q;
                            zero_q <= zero_q & ~maj;
                        end
                        if (sc_last) state_q <= STOP1;
                    end
                    STOP1: begin
                        if (decide) begin
                            if (stop2_q) begin
                                ferr_q <= ferr_now;
                                zero_q <= stop_zero;
                            end else if (stop_zero) begin
                                break_q <= 1'b1;
                                state_q <= BREAK_WAIT;
                            end else begin
                                push_q      <= 1'b1;
                                push_word_q <= {data_q, perr_q, ferr_now};
                                state_q     <= IDLE;
                            end
                        end
                        if (sc_last && stop2_q) state_q <= STOP2;
                    end
                    STOP2: begin
                        if (decide) begin
                            if (stop_zero) begin
                                break_q <= 1'b1;
                                state_q <= BREAK_WAIT;
                            end else begin
                                push_q      <= 1'b1;
                                push_word_q <= {data_q, perr_q, ferr_now};
                                state_q     <= IDLE;
                            end
                        end
                    end
                    BREAK_WAIT: begin
                        if (rxs_q) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // ---------------- receive FIFO ----------------
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overrun_q;
    logic              pop, full, wr_en;
    logic [WORD_W-1:0] head;

    assign pop   = rx_if.valid & rx_if.ready;
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the new word needs.
    assign wr_en = push_q & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_word_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
            if (push_q && full && !pop)
                overrun_q <= 1'b1;
            else if (pop)
                overrun_q <= 1'b0;
        end
    end

    assign head                 = mem_q[rd_ptr_q];
    assign rx_if.data_out       = head[WORD_W-1:2];
    assign rx_if.parity_err_out = head[1];
    assign rx_if.frame_err_out  = head[0];
    assign rx_if.valid          = (count_q != '0);
    assign break_det            = break_q;
    assign overrun              = overrun_q;
    assign fifo_level           = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       rx;
    logic       parity_en, parity_odd, stop_bits;
    logic [3:0] frame_length;
    logic       break_det, overrun;
    logic [2:0] fifo_level;

    uart_rx_fifo_if #(.MAX_DATA_BITS(9)) bus ();

    uart_rx_fifo #(.OVERSAMPLE(OS), .MAX_DATA_BITS(9), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .rx           (rx),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .stop_bits    (stop_bits),
        .frame_length (frame_length),
        .rx_if        (bus),
        .break_det    (break_det),
        .overrun      (overrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int brk_cnt = 0;
    int brk_expect = 0;
    int model_level = 0;
    int div = 1;
    int phase = 0;
    logic [10:0] sb [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, strobing sample_en once every div clocks.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            sample_en = (phase == 0);
            phase = (phase + 1) % div;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int clamp_len(input logic [3:0] fl);
        if (fl < 5) return 5;
        if (fl > 9) return 9;
        return int'(fl);
    endfunction

    // Drive one frame with the current config, predicting its outcome.
    task automatic send_frame(input logic [8:0] d, input logic pbit, input logic s1,
                              input logic s2, input int tail_low);
        int nb;
        int bitlen;
        logic [8:0] dm;
        logic perr, ferr, brk;
        nb = clamp_len(frame_length);
        bitlen = OS * div;
        dm = '0;
        for (int i = 0; i < nb; i++) dm[i] = d[i];
        perr = parity_en ? ((^dm) ^ pbit ^ parity_odd) : 1'b0;
        ferr = !s1 || (stop_bits && !s2);
        brk  = (dm == 0) && (!parity_en || !pbit) && !s1 && (!stop_bits || !s2);
        if (brk)
            brk_expect++;
        else if (model_level < DEPTH) begin
            sb.push_back({dm, perr, ferr});
            model_level++;
        end
        rx = 1'b0; tick(bitlen);
        for (int i = 0; i < nb; i++) begin rx = d[i]; tick(bitlen); end
        if (parity_en) begin rx = pbit; tick(bitlen); end
        rx = s1; tick(bitlen);
        if (stop_bits) begin rx = s2; tick(bitlen); end
        rx = 1'b0; tick(bitlen * tail_low);
        rx = 1'b1; tick(bitlen * 2);
        $display("frame d=0x%03h nb=%0d par=%0d pbit=%0d stops=%b%b -> exp perr=%0b ferr=%0b brk=%0b",
                 d, nb, parity_en, pbit, s1, s2, perr, ferr, brk);
    endtask

    task automatic drain();
        bus.ready = 1'b1;
        for (int k = 0; k < 50 && bus.valid; k++) tick(1);
        bus.ready = 1'b0;
        check_val("drain_valid", bus.valid, 0);
        check_val("sb_empty", sb.size(), 0);
    endtask

    // Scoreboard consumer: compare each popped head word.
    always @(negedge clk) begin
        if (break_det) brk_cnt++;
        if (rst && bus.valid && bus.ready) begin
            if (sb.size() == 0)
                check_val("unexpected_pop", {bus.data_out, bus.parity_err_out, bus.frame_err_out}, 0);
            else begin
                logic [10:0] e;
                e = sb.pop_front();
                check_val("sb_word", {bus.data_out, bus.parity_err_out, bus.frame_err_out}, e);
                $display("pop data=0x%03h perr=%0b ferr=%0b", bus.data_out, bus.parity_err_out, bus.frame_err_out);
                model_level--;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rx = 1'b1; sample_en = 1'b0; bus.ready = 1'b0;
        parity_en = 1'b1; parity_odd = 1'b0; stop_bits = 1'b0; frame_length = 4'd8;
        tick(5);
        check_val("rst_data", bus.data_out, 0);
        check_val("rst_valid", bus.valid, 0);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_break", break_det, 0);
        rst = 1'b1;
        tick(40);

        // 1: 8E1 frame 0x065
        send_frame(9'h065, 1'b0, 1'b1, 1'b1, 0);
        check_val("t1_data", bus.data_out, 9'h065);
        check_val("t1_perr", bus.parity_err_out, 0);
        check_val("t1_ferr", bus.frame_err_out, 0);
        check_val("t1_valid", bus.valid, 1);
        check_val("t1_level", fifo_level, 1);
        drain();

        // 2: parity error, then odd parity accepting the same bit
        send_frame(9'h065, 1'b1, 1'b1, 1'b1, 0);
        check_val("t2_perr", bus.parity_err_out, 1);
        check_val("t2_data", bus.data_out, 9'h065);
        drain();
        parity_odd = 1'b1;
        send_frame(9'h065, 1'b1, 1'b1, 1'b1, 0);
        check_val("t2_odd_perr", bus.parity_err_out, 0);
        drain();
        parity_odd = 1'b0;

        // 3: short glitch rejected, then a good frame
        rx = 1'b0; tick(5);
        rx = 1'b1; tick(OS * 3);
        check_val("t3_glitch_level", fifo_level, 0);
        send_frame(9'h047, 1'b0, 1'b1, 1'b1, 0);
        check_val("t3_data", bus.data_out, 9'h047);
        drain();

        // 4: second stop low -> framing error; all-zero -> break
        stop_bits = 1'b1;
        send_frame(9'h065, 1'b0, 1'b1, 1'b0, 0);
        check_val("t4_ferr", bus.frame_err_out, 1);
        drain();
        send_frame(9'h000, 1'b0, 1'b0, 1'b0, 3);
        check_val("t4_break_pulses", brk_cnt, brk_expect);
        check_val("t4_break_nopush", fifo_level, 0);
        stop_bits = 1'b0;
        parity_en = 1'b0;
        send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, 0);
        check_val("t4_after_break", bus.data_out, 9'h0A5);
        drain();

        // 5: overrun
        for (int i = 1; i <= 5; i++) send_frame(9'(i), 1'b0, 1'b1, 1'b1, 0);
        check_val("t5_level", fifo_level, 4);
        check_val("t5_overrun", overrun, 1);
        check_val("t5_head", bus.data_out, 9'h001);
        bus.ready = 1'b1; tick(1); bus.ready = 1'b0;
        check_val("t5_overrun_clr", overrun, 0);
        check_val("t5_level_after_pop", fifo_level, 3);
        drain();

        // 6: length clamp, reset mid-frame, slow strobe
        frame_length = 4'd3;
        send_frame(9'h015, 1'b0, 1'b1, 1'b1, 0);
        check_val("t6_clamp", bus.data_out, 9'h015);
        frame_length = 4'd8;
        rx = 1'b0; tick(OS);
        rx = 1'b1; tick(OS);
        rx = 1'b0; tick(OS / 2);
        rst = 1'b0;
        tick(2);
        sb.delete(); model_level = 0;
        check_val("t6_rst_data", bus.data_out, 0);
        check_val("t6_rst_valid", bus.valid, 0);
        check_val("t6_rst_level", fifo_level, 0);
        rx = 1'b1; tick(2);
        rst = 1'b1; tick(OS * 2);
        send_frame(9'h0C3, 1'b0, 1'b1, 1'b1, 0);
        check_val("t6_after_rst", bus.data_out, 9'h0C3);
        drain();
        div = 3; phase = 0;
        send_frame(9'h13C, 1'b0, 1'b1, 1'b1, 0);
        check_val("t6_slow_strobe", bus.data_out, 9'h03C);
        drain();
        check_val("final_breaks", brk_cnt, brk_expect);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
